// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU opcodes, RV32I major opcodes,
// operand/immediate selectors and the decoded control bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_AND  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
  typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} opa_sel_e;
  typedef enum logic [1:0] {OPB_RS2, OPB_IMM, OPB_FOUR} opb_sel_e;

  typedef struct packed {
    alu_op_e  alu_op;
    opa_sel_e opa_sel;
    opb_sel_e opb_sel;
    logic     rd_wren;
    logic     mem_rd;
    logic     mem_wr;
    logic     is_branch;
    logic     is_jump;
  } dec_ctrl_t;

  // NOP: 0 + 0 with no side effects; the immediate is forced to zero by the decoder.
  localparam dec_ctrl_t NOP_CTRL = '{ALU_ADD, OPA_ZERO, OPB_IMM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] imm32(input logic [31:0] instr, input imm_sel_e sel);
    logic [31:0] v;
    case (sel)
      IMM_I:   v = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   v = {instr[31:12], 12'b0};
      IMM_J:   v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decoder: instruction word to control bundle and immediate.
// With ALU_ISSUE_ILLEGAL_EN defined an 'illegal' flag output is added.
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output dec_ctrl_t       ctrl,
  output logic [XLEN-1:0] imm
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  dec_ctrl_t   ctrl_raw;
  imm_sel_e    imm_sel;
  logic        use_shamt;
  logic        bad;
  logic [31:0] imm_raw;

  always_comb begin
    ctrl_raw  = NOP_CTRL;
    imm_sel   = IMM_I;
    use_shamt = 1'b0;
    bad       = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl_raw.alu_op  = alu_from_funct3(funct3, funct7[5]);
        ctrl_raw.opa_sel = OPA_RS1;
        ctrl_raw.opb_sel = OPB_RS2;
        ctrl_raw.rd_wren = 1'b1;
        bad = !((funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        // funct7[5] only means "arithmetic" for right shifts; ADDI has no SUB form.
        ctrl_raw.alu_op  = alu_from_funct3(funct3, funct7[5] & (funct3 == 3'b101));
        ctrl_raw.opa_sel = OPA_RS1;
        ctrl_raw.opb_sel = OPB_IMM;
        ctrl_raw.rd_wren = 1'b1;
        if (funct3 == 3'b001) begin
          use_shamt = 1'b1;
          bad       = (funct7 != 7'h00);
        end else if (funct3 == 3'b101) begin
          use_shamt = 1'b1;
          bad       = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
      end
      OPC_LUI: begin
        ctrl_raw.opb_sel = OPB_IMM;
        ctrl_raw.rd_wren = 1'b1;
        imm_sel          = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl_raw.opa_sel = OPA_PC;
        ctrl_raw.opb_sel = OPB_IMM;
        ctrl_raw.rd_wren = 1'b1;
        imm_sel          = IMM_U;
      end
      OPC_JAL, OPC_JALR: begin
        ctrl_raw.opa_sel = OPA_PC;
        ctrl_raw.opb_sel = OPB_FOUR;
        ctrl_raw.rd_wren = 1'b1;
        ctrl_raw.is_jump = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_raw.opa_sel = OPA_RS1;
        ctrl_raw.opb_sel = OPB_IMM;
        ctrl_raw.rd_wren = 1'b1;
        ctrl_raw.mem_rd  = 1'b1;
      end
      OPC_STORE: begin
        ctrl_raw.opa_sel = OPA_RS1;
        ctrl_raw.opb_sel = OPB_IMM;
        ctrl_raw.mem_wr  = 1'b1;
        imm_sel          = IMM_S;
      end
      OPC_BRANCH: begin
        ctrl_raw.opa_sel   = OPA_RS1;
        ctrl_raw.opb_sel   = OPB_RS2;
        ctrl_raw.is_branch = 1'b1;
        case (funct3[2:1])
          2'b10:   ctrl_raw.alu_op = ALU_SLT;
          2'b11:   ctrl_raw.alu_op = ALU_SLTU;
          default: ctrl_raw.alu_op = ALU_SUB;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
  end

  assign imm_raw = use_shamt ? {27'b0, instr[24:20]} : imm32(instr, imm_sel);

  always_comb begin
    if (bad) begin
      ctrl = NOP_CTRL;
      imm  = '0;
    end else begin
      ctrl         = ctrl_raw;
      ctrl.rd_wren = ctrl_raw.rd_wren & (instr[11:7] != 5'd0);
      imm          = XLEN'($signed(imm_raw));
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  assign illegal = bad;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue pipeline register in front of the ALU with valid/ready, flush and
// an issued-instruction counter. ALU_ISSUE_ILLEGAL_EN adds a registered 'illegal' output.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_op,
  output logic [XLEN-1:0]  operand_a,
  output logic [XLEN-1:0]  operand_b,
  output logic [XLEN-1:0]  store_data,
  output logic [4:0]       rd_addr,
  output logic             rd_wren,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             is_branch,
  output logic             is_jump,
  output logic [2:0]       funct3_q,
  output logic [CNT_W-1:0] issue_cnt
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic             illegal
`endif
);

  dec_ctrl_t       dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] opa_val;
  logic [XLEN-1:0] opb_val;
  logic            accept;
  logic            issue;

  logic             out_valid_q,  out_valid_d;
  alu_op_e          alu_op_q,     alu_op_d;
  logic [XLEN-1:0]  operand_a_q,  operand_a_d;
  logic [XLEN-1:0]  operand_b_q,  operand_b_d;
  logic [XLEN-1:0]  store_data_q, store_data_d;
  logic [4:0]       rd_addr_q,    rd_addr_d;
  logic             rd_wren_q,    rd_wren_d;
  logic             mem_rd_q,     mem_rd_d;
  logic             mem_wr_q,     mem_wr_d;
  logic             is_branch_q,  is_branch_d;
  logic             is_jump_q,    is_jump_d;
  logic [2:0]       funct3_d;
  logic [CNT_W-1:0] issue_cnt_q,  issue_cnt_d;

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic dec_illegal;
  logic illegal_q, illegal_d;

  alu_issue_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );
`else
  alu_issue_decode #(.XLEN(XLEN)) u_decode (
    .instr (instr),
    .ctrl  (dec_ctrl),
    .imm   (dec_imm)
  );
`endif

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign issue    = out_valid_q & out_ready;

  always_comb begin
    case (dec_ctrl.opa_sel)
      OPA_RS1: opa_val = rs1_data;
      OPA_PC:  opa_val = pc;
      default: opa_val = '0;
    endcase
    case (dec_ctrl.opb_sel)
      OPB_RS2:  opb_val = rs2_data;
      OPB_FOUR: opb_val = XLEN'(4);
      default:  opb_val = dec_imm;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    alu_op_d     = alu_op_q;
    operand_a_d  = operand_a_q;
    operand_b_d  = operand_b_q;
    store_data_d = store_data_q;
    rd_addr_d    = rd_addr_q;
    rd_wren_d    = rd_wren_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    is_branch_d  = is_branch_q;
    is_jump_d    = is_jump_q;
    funct3_d     = funct3_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
    illegal_d    = illegal_q;
`endif
    // The counter tracks issues independently, so an issue coinciding with flush still counts.
    issue_cnt_d  = issue_cnt_q + CNT_W'(issue);

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      alu_op_d     = dec_ctrl.alu_op;
      operand_a_d  = opa_val;
      operand_b_d  = opb_val;
      store_data_d = rs2_data;
      rd_addr_d    = instr[11:7];
      rd_wren_d    = dec_ctrl.rd_wren;
      mem_rd_d     = dec_ctrl.mem_rd;
      mem_wr_d     = dec_ctrl.mem_wr;
      is_branch_d  = dec_ctrl.is_branch;
      is_jump_d    = dec_ctrl.is_jump;
      funct3_d     = instr[14:12];
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_d    = dec_illegal;
`endif
    end else if (issue) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      alu_op_q     <= ALU_ADD;
      operand_a_q  <= '0;
      operand_b_q  <= '0;
      store_data_q <= '0;
      rd_addr_q    <= '0;
      rd_wren_q    <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      is_branch_q  <= 1'b0;
      is_jump_q    <= 1'b0;
      funct3_q     <= '0;
      issue_cnt_q  <= '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      alu_op_q     <= alu_op_d;
      operand_a_q  <= operand_a_d;
      operand_b_q  <= operand_b_d;
      store_data_q <= store_data_d;
      rd_addr_q    <= rd_addr_d;
      rd_wren_q    <= rd_wren_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      is_branch_q  <= is_branch_d;
      is_jump_q    <= is_jump_d;
      funct3_q     <= funct3_d;
      issue_cnt_q  <= issue_cnt_d;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_q    <= illegal_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_op     = alu_op_q;
  assign operand_a  = operand_a_q;
  assign operand_b  = operand_b_q;
  assign store_data = store_data_q;
  assign rd_addr    = rd_addr_q;
  assign rd_wren    = rd_wren_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign is_branch  = is_branch_q;
  assign is_jump    = is_jump_q;
  assign issue_cnt  = issue_cnt_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign illegal    = illegal_q;
`endif

endmodule
